bt656_tx: RTL

BT656_TX -- requirements
Module: bt656_tx

---
 rtl/bt656_tx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bt656_tx.sv
// BT.656 test-pattern transmitter: emits EAV/blank/SAV/active bytes per line with
// ramp or solid-colour active video and registered sync/strobe outputs.
module bt656_tx #(
    parameter int DW       = 8,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 272,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          pattern_sel_i,
    input  logic [23:0]   color_i,
    output logic [DW-1:0] data_o,
    output logic          href_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_start_o
);

    localparam int LINES     = V_BLANK + V_ACTIVE;
    localparam int ACT_BYTES = 2 * H_ACTIVE;
    localparam int CMAX      = (ACT_BYTES > H_BLANK) ? ACT_BYTES : H_BLANK;
    // at least 9 bits so cnt[8:1] can always supply the ramp pixel index
    localparam int CW        = ($clog2(CMAX) < 9) ? 9 : $clog2(CMAX);
    localparam int LW        = ($clog2(LINES) < 1) ? 1 : $clog2(LINES);

    typedef enum logic [2:0] {IDLE, EAV, HBLANK, SAV, ACTIVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [LW-1:0] line, line_nxt;
    logic          pat, pat_nxt;
    logic [23:0]   col, col_nxt;
    logic          start;

    logic [7:0]    data_nxt;
    logic          href_nxt, hsync_nxt, vsync_nxt, fs_nxt;
    logic          vblank, sync_h;
    logic [7:0]    xy, y_val, cb_val, cr_val;

    function automatic logic [7:0] clamp(input logic [7:0] v);
        if (v == 8'h00)      return 8'h01;
        else if (v == 8'hFF) return 8'hFE;
        else                 return v;
    endfunction

    // Next-state: state/cnt/line describe the byte that will be on the outputs next cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        line_nxt  = line;
        pat_nxt   = pat;
        col_nxt   = col;
        start     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                line_nxt = '0;
                if (enable_i) start = 1'b1;
            end
            EAV: begin
                if (cnt == CW'(3)) begin
                    state_nxt = HBLANK;
                    cnt_nxt   = '0;
                end
            end
            HBLANK: begin
                if (cnt == CW'(H_BLANK - 1)) begin
                    state_nxt = SAV;
                    cnt_nxt   = '0;
                end
            end
            SAV: begin
                if (cnt == CW'(3)) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (cnt == CW'(ACT_BYTES - 1)) begin
                    cnt_nxt = '0;
                    if (line == LW'(LINES - 1)) begin
                        if (enable_i) begin
                            start = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            line_nxt  = '0;
                        end
                    end else begin
                        state_nxt = EAV;
                        line_nxt  = line + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                line_nxt  = '0;
            end
        endcase
        // pattern controls are captured only here, on the first EAV byte of a frame
        if (start) begin
            state_nxt = EAV;
            cnt_nxt   = '0;
            line_nxt  = '0;
            pat_nxt   = pattern_sel_i;
            col_nxt   = color_i;
        end
    end

    // Output decode from the next state so every output comes straight from a flop
    always_comb begin
        data_nxt  = 8'h00;
        href_nxt  = 1'b0;
        hsync_nxt = 1'b0;
        vsync_nxt = 1'b0;
        fs_nxt    = start;
        vblank    = (line_nxt < LW'(V_BLANK));
        sync_h    = (state_nxt == EAV);
        xy        = {1'b1, 1'b0, vblank, sync_h, vblank ^ sync_h, sync_h, vblank, vblank ^ sync_h};
        cb_val    = pat_nxt ? clamp(col_nxt[15:8])  : 8'h80;
        cr_val    = pat_nxt ? clamp(col_nxt[7:0])   : 8'h80;
        y_val     = pat_nxt ? clamp(col_nxt[23:16]) : clamp(cnt_nxt[8:1]);
        case (state_nxt)
            EAV, SAV: begin
                hsync_nxt = 1'b1;
                vsync_nxt = vblank;
                case (cnt_nxt[1:0])
                    2'd0:    data_nxt = 8'hFF;
                    2'd3:    data_nxt = xy;
                    default: data_nxt = 8'h00;
                endcase
            end
            HBLANK: begin
                hsync_nxt = 1'b1;
                vsync_nxt = vblank;
                data_nxt  = cnt_nxt[0] ? 8'h10 : 8'h80;
            end
            ACTIVE: begin
                vsync_nxt = vblank;
                href_nxt  = ~vblank;
                if (vblank) begin
                    data_nxt = cnt_nxt[0] ? 8'h10 : 8'h80;
                end else begin
                    case (cnt_nxt[1:0])
                        2'd0:    data_nxt = cb_val;
                        2'd2:    data_nxt = cr_val;
                        default: data_nxt = y_val;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            line          <= '0;
            pat           <= 1'b0;
            col           <= '0;
            data_o        <= '0;
            href_o        <= 1'b0;
            hsync_o       <= 1'b0;
            vsync_o       <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            line          <= line_nxt;
            pat           <= pat_nxt;
            col           <= col_nxt;
            data_o        <= data_nxt;
            href_o        <= href_nxt;
            hsync_o       <= hsync_nxt;
            vsync_o       <= vsync_nxt;
            frame_start_o <= fs_nxt;
        end
    end

endmodule
